pmem_line_fetch: RTL and testbench

- Program-memory front end that sits directly upstream of the instruction fetch queue.
- Accepts a line-fetch request (m_rd_en, mem_addr) from the queue and issues four pipelined 32-bit word reads to the word-wide program ROM. It assembles the four words into one 128-bit line and returns it with a single-cycle d_valid pulse.
- Supports abort of an in-flight line, including draining outstanding word responses.

---
 rtl/pmem_line_fetch_pkg.sv | 15 +
 rtl/pmem_line_fetch_if.sv | 29 ++
 rtl/pmem_line_fetch_line_asm.sv | 39 +++
 rtl/pmem_line_fetch.sv | 144 ++++++++++++++
 tb/tb_pmem_line_fetch.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmem_line_fetch_pkg.sv
// rtl/pmem_line_fetch_pkg.sv - shared types and constants for the program-memory line fetcher
package pmem_pkg;

    localparam int          LINE_WORDS = 4;
    localparam int          LINE_BYTES = 16;
    localparam logic [31:0] RESET_PC   = 32'h0040_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } pmem_state_e;

endpackage

// File: rtl/pmem_line_fetch_if.sv
// rtl/pmem_line_fetch_if.sv - word-wide program ROM request/response bus
interface pmem_line_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);

    logic              w_rd_en;
    logic [ADDR_W-1:0] w_addr;
    logic              w_ready;
    logic              w_valid;
    logic [WORD_W-1:0] w_rdata;

    modport master (
        output w_rd_en,
        output w_addr,
        input  w_ready,
        input  w_valid,
        input  w_rdata
    );

    modport slave (
        input  w_rd_en,
        input  w_addr,
        output w_ready,
        output w_valid,
        output w_rdata
    );

endinterface

// File: rtl/pmem_line_fetch_line_asm.sv
// rtl/pmem_line_fetch_line_asm.sv - line assembly register with word-indexed writes
module line_asm
    import pmem_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int N_WORDS = LINE_WORDS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic [$clog2(N_WORDS)-1:0]  idx,
    input  logic [WORD_W-1:0]           wdata,
    output logic [N_WORDS*WORD_W-1:0]   line
);

    logic [N_WORDS*WORD_W-1:0] line_q;
    logic [N_WORDS*WORD_W-1:0] line_d;

    always_comb begin
        line_d = line_q;
        if (clr) begin
            line_d = '0;
        end else if (wr_en) begin
            line_d[idx*WORD_W +: WORD_W] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line = line_q;

endmodule

// File: rtl/pmem_line_fetch.sv
// rtl/pmem_line_fetch.sv - fetches a 4-word program line from a word ROM and returns it as one beat
module pmem_line_fetch
    import pmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_rd_en,
    input  logic [ADDR_W-1:0]            mem_addr,
    input  logic                         abort,
    output logic                         d_valid,
    output logic [LINE_WORDS*WORD_W-1:0] mem_data,
    output logic                         busy,
    pmem_line_fetch_if.master            rom
);

    localparam logic [2:0] CNT_FULL = 3'(LINE_WORDS);
    localparam logic [2:0] LAST_IDX = 3'(LINE_WORDS - 1);

    pmem_state_e                  state_q, state_d;
    logic [ADDR_W-1:4]            base_q, base_d;
    logic [2:0]                   issue_q, issue_d;
    logic [2:0]                   ret_q, ret_d;
    logic [2:0]                   outst_q, outst_d;
    logic [LINE_WORDS*WORD_W-1:0] mem_data_q, mem_data_d;

    logic                         w_rd_en;
    logic                         issue_fire;
    logic                         asm_clr;
    logic                         asm_wr;
    logic [LINE_WORDS*WORD_W-1:0] asm_line;
    logic                         unused_addr_bits;

    assign unused_addr_bits = ^mem_addr[3:0];

    line_asm #(
        .WORD_W  (WORD_W),
        .N_WORDS (LINE_WORDS)
    ) u_line_asm (
        .clk   (clk),
        .rst   (rst),
        .clr   (asm_clr),
        .wr_en (asm_wr),
        .idx   (ret_q[1:0]),
        .wdata (rom.w_rdata),
        .line  (asm_line)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        issue_d    = issue_q;
        ret_d      = ret_q;
        outst_d    = outst_q;
        mem_data_d = mem_data_q;
        w_rd_en    = 1'b0;
        issue_fire = 1'b0;
        asm_clr    = 1'b0;
        asm_wr     = 1'b0;
        d_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                if (m_rd_en && !abort) begin
                    base_d  = mem_addr[ADDR_W-1:4];
                    issue_d = 3'd0;
                    ret_d   = 3'd0;
                    outst_d = 3'd0;
                    asm_clr = 1'b1;
                    state_d = FETCH;
                end
            end

            FETCH: begin
                w_rd_en    = (issue_q < CNT_FULL) && !abort;
                issue_fire = w_rd_en && rom.w_ready;
                if (issue_fire) begin
                    issue_d = issue_q + 3'd1;
                end
                if (rom.w_valid) begin
                    ret_d = ret_q + 3'd1;
                end
                outst_d = outst_q + {2'b00, issue_fire} - {2'b00, rom.w_valid};
                // An abort still retires a coincident return, but its data never lands.
                if (abort) begin
                    state_d = (outst_d == 3'd0) ? IDLE : DRAIN;
                end else begin
                    asm_wr = rom.w_valid;
                    if (rom.w_valid && (ret_q == LAST_IDX)) begin
                        state_d = RESP;
                    end
                end
            end

            RESP: begin
                d_valid = !abort;
                if (!abort) begin
                    mem_data_d = asm_line;
                end
                state_d = IDLE;
            end

            DRAIN: begin
                if (rom.w_valid) begin
                    outst_d = outst_q - 3'd1;
                end
                if (outst_d == 3'd0) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            issue_q    <= 3'd0;
            ret_q      <= 3'd0;
            outst_q    <= 3'd0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            issue_q    <= issue_d;
            ret_q      <= ret_d;
            outst_q    <= outst_d;
            mem_data_q <= mem_data_d;
        end
    end

    // The completed line is forwarded during the pulse so mem_data is valid alongside d_valid.
    assign mem_data    = d_valid ? asm_line : mem_data_q;
    assign busy        = (state_q != IDLE);
    assign rom.w_rd_en = w_rd_en;
    assign rom.w_addr  = {base_q, issue_q[1:0], 2'b00};

endmodule

// File: tb/tb_pmem_line_fetch.sv
// tb/tb_pmem_line_fetch.sv - randomized bench for pmem_line_fetch against a line-level ROM model
module tb_pmem_line_fetch;
    import pmem_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         m_rd_en;
    logic [31:0]  mem_addr;
    logic         abort;
    logic         d_valid;
    logic [127:0] mem_data;
    logic         busy;

    pmem_line_fetch_if rom_if ();

    pmem_line_fetch dut (
        .clk      (clk),
        .rst      (rst),
        .m_rd_en  (m_rd_en),
        .mem_addr (mem_addr),
        .abort    (abort),
        .d_valid  (d_valid),
        .mem_data (mem_data),
        .busy     (busy),
        .rom      (rom_if.master)
    );

    always #5 clk = ~clk;

    int           cyc = 0;
    int           lat = 1;
    int           ready_mode = 0;
    bit           toggle_ph = 1'b1;
    bit           plain = 1'b1;
    logic [31:0]  salt = 32'h0;
    logic [31:0]  rq_addr[$];
    int           rq_due[$];
    logic [31:0]  iss_log[$];
    logic [127:0] dvd_q[$];
    int           dvc_q[$];
    int           last_ret_cyc = 0;
    logic [127:0] last_line_exp = '0;
    int           n_pass = 0;
    int           n_chk = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [31:0] k;
        k = {30'd0, a[3:2]} + 32'd1;
        if (plain) return k * 32'h1111_1111;
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    function automatic logic [127:0] exp_line(input logic [31:0] base);
        logic [127:0] l;
        l = '0;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = rom_word(base + 32'(4*k));
        return l;
    endfunction

    // One clock: ROM drives at the falling edge, outputs sampled 1 ns later, inputs change after the rising edge.
    task automatic tick();
        @(negedge clk);
        case (ready_mode)
            0:       rom_if.w_ready = 1'b1;
            1:       rom_if.w_ready = toggle_ph;
            default: rom_if.w_ready = 1'($urandom_range(0, 1));
        endcase
        toggle_ph = ~toggle_ph;
        if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            rom_if.w_valid = 1'b1;
            rom_if.w_rdata = rom_word(rq_addr[0]);
            void'(rq_addr.pop_front());
            void'(rq_due.pop_front());
            last_ret_cyc = cyc;
        end else begin
            rom_if.w_valid = 1'b0;
            rom_if.w_rdata = $urandom;
        end
        #1;
        if (rom_if.w_rd_en && rom_if.w_ready) begin
            iss_log.push_back(rom_if.w_addr);
            rq_addr.push_back(rom_if.w_addr);
            rq_due.push_back(cyc + lat);
        end
        if (d_valid) begin
            dvd_q.push_back(mem_data);
            dvc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_rom_empty();
        int n;
        n = 0;
        while (rq_due.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("rom_drain_timeout", 1, 0);
    endtask

    task automatic run_line(input logic [31:0] addr, input int exp_lat, input string tag);
        logic [31:0] base;
        int start, n, d0;
        base = {addr[31:4], 4'h0};
        iss_log.delete();
        d0 = dvd_q.size();
        mem_addr = addr;
        m_rd_en = 1'b1;
        start = cyc;
        tick();
        m_rd_en = 1'b0;
        mem_addr = $urandom;
        n = 0;
        while (dvd_q.size() == d0 && n < 200) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk({tag, "_pulses"}, 128'(dvd_q.size() - d0), 1);
        if (dvd_q.size() > d0) begin
            chk({tag, "_data"}, dvd_q[d0], exp_line(base));
            chk({tag, "_ret_to_dv"}, 128'(dvc_q[d0]), 128'(last_ret_cyc + 1));
            if (exp_lat >= 0) chk({tag, "_latency"}, 128'(dvc_q[d0] - start), 128'(exp_lat));
        end
        chk({tag, "_nissue"}, 128'(iss_log.size()), 4);
        for (int k = 0; k < iss_log.size() && k < 4; k++)
            chk({tag, "_waddr"}, iss_log[k], base + 32'(4*k));
        chk({tag, "_held"}, mem_data, exp_line(base));
        chk({tag, "_idle"}, busy, 0);
        last_line_exp = exp_line(base);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int d0, start, n;
        bit dropped;
        rst = 1'b1;
        m_rd_en = 1'b0;
        mem_addr = '0;
        abort = 1'b0;
        rom_if.w_ready = 1'b0;
        rom_if.w_valid = 1'b0;
        rom_if.w_rdata = '0;
        repeat (2) tick();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_d_valid", d_valid, 0);
        chk("reset_w_rd_en", rom_if.w_rd_en, 0);
        chk("reset_w_addr", rom_if.w_addr, 0);
        chk("reset_mem_data", mem_data, 0);

        // basic fetch, known data pattern
        plain = 1'b1; lat = 1; ready_mode = 0;
        run_line(32'h0040_0004, 6, "basic");
        chk("basic_literal", last_line_exp, 128'h44444444_33333333_22222222_11111111);

        // backpressure with toggling ready and latency 3
        plain = 1'b0; salt = $urandom; lat = 3; ready_mode = 1; toggle_ph = 1'b0;
        run_line(RESET_PC + 32'h40, -1, "bp");

        // abort two cycles into FETCH, two words outstanding
        lat = 3; ready_mode = 0; salt = $urandom;
        iss_log.delete();
        d0 = dvd_q.size();
        mem_addr = RESET_PC + 32'h80; m_rd_en = 1'b1;
        tick();
        m_rd_en = 1'b0;
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abf_drain_busy0", busy, 128'(rq_due.size() > 0));
        m_rd_en = 1'b1;
        tick();
        chk("abf_drain_busy1", busy, 128'(rq_due.size() > 0));
        tick();
        m_rd_en = 1'b0;
        chk("abf_idle", busy, 128'(rq_due.size() > 0));
        repeat (3) tick();
        chk("abf_nissue", 128'(iss_log.size()), 2);
        chk("abf_no_dv", 128'(dvd_q.size() - d0), 0);
        chk("abf_mem_hold", mem_data, last_line_exp);

        // abort coincident with RESP
        lat = 1; ready_mode = 0; salt = $urandom;
        d0 = dvd_q.size();
        mem_addr = RESET_PC + 32'hC0; m_rd_en = 1'b1;
        tick();
        m_rd_en = 1'b0;
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (2) tick();
        chk("abr_no_dv", 128'(dvd_q.size() - d0), 0);
        chk("abr_mem_hold", mem_data, last_line_exp);
        chk("abr_idle", busy, 0);
        run_line(RESET_PC + 32'h100, 6, "after_abr");

        // back-to-back lines with m_rd_en held
        iss_log.delete();
        d0 = dvd_q.size();
        mem_addr = RESET_PC; m_rd_en = 1'b1; start = cyc;
        tick();
        mem_addr = RESET_PC + 32'h10;
        n = 0; dropped = 1'b0;
        while (dvd_q.size() - d0 < 2 && n < 100) begin
            tick();
            n++;
            if (dvd_q.size() - d0 == 1 && !dropped) begin
                tick();
                m_rd_en = 1'b0;
                dropped = 1'b1;
            end
        end
        m_rd_en = 1'b0;
        repeat (3) tick();
        chk("b2b_pulses", 128'(dvd_q.size() - d0), 2);
        if (dvd_q.size() - d0 >= 2) begin
            chk("b2b_lat0", 128'(dvc_q[d0] - start), 6);
            chk("b2b_lat1", 128'(dvc_q[d0+1] - start), 13);
            chk("b2b_data0", dvd_q[d0], exp_line(RESET_PC));
            chk("b2b_data1", dvd_q[d0+1], exp_line(RESET_PC + 32'h10));
        end
        chk("b2b_nissue", 128'(iss_log.size()), 8);
        for (int k = 0; k < iss_log.size() && k < 8; k++)
            chk("b2b_waddr", iss_log[k], RESET_PC + 32'(4*k));
        last_line_exp = exp_line(RESET_PC + 32'h10);

        // reset after two issues
        lat = 3; ready_mode = 0;
        d0 = dvd_q.size();
        mem_addr = RESET_PC + 32'h200; m_rd_en = 1'b1;
        tick();
        m_rd_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_w_rd_en", rom_if.w_rd_en, 0);
        chk("rst_w_addr", rom_if.w_addr, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_mem_data", mem_data, 0);
        wait_rom_empty();
        tick();
        chk("rst_late_ignored", 128'(dvd_q.size() - d0), 0);
        chk("rst_late_idle", busy, 0);
        run_line(RESET_PC + 32'h240, 8, "after_rst");

        // randomized lines: latency, ready pattern, address and data
        for (int i = 0; i < 24; i++) begin
            lat = $urandom_range(1, 4);
            ready_mode = $urandom_range(0, 2);
            salt = $urandom;
            run_line($urandom, (ready_mode == 0) ? 5 + lat : -1, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
